missile_scheduler: RTL and testbench
====================================

// Module: missile_scheduler
// PURPOSE
//   Owns the pool of NUM_MISSILES player missile slots in the VGA game peripheral.
//   Turns the fire button into launch requests and allocates the lowest free slot at the gun position.
//   Advances every in-flight missile on a divided motion tick and frees slots at the screen top or on hit.
//   Drives per-slot enable/row/column to the sprite renderer, which only draws the pixels.
// PARAMETERS
//   NUM_MISSILES    8       number of missile slots (1..16)
//   TICK_DIV        500000  clk cycles per motion tick
//   COOLDOWN_TICKS  4       motion ticks between launches
//   START_ROW       460     row loaded into a newly launched missile
//   STEP            2       rows a missile moves up per motion tick
//   COL_OFFSET      8       gun column offset from player_col
// PORTS
//   clk           in   1        pixel/system clock
//   rst           in   1        asynchronous active-high reset
//   fire_btn      in   1        fire button level, already synchronised/debounced
//   player_col    in   12       player sprite left column
//   hit_valid     in   1        collision logic reports a missile hit this cycle
//   hit_idx       in   4        slot index hit (ignored if >= NUM_MISSILES)
//   missile_en    out  N        slot i in flight
//   missile_row   out  N*12     packed rows, slot i at [12*i +: 12]
//   missile_col   out  N*12     packed columns, same packing
//   fire_ack      out  1        1-cycle pulse: launch succeeded
//   fire_drop     out  1        1-cycle pulse: launch requested, all slots busy
//   motion_tick   out  1        1-cycle pulse every TICK_DIV clocks
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, tick and cooldown counters 0. Reset mid-flight drops all missiles immediately.
//   Tick: counter runs 0..TICK_DIV-1. motion_tick=1 in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
//   FSM states:
//     IDLE: a fire request moves the FSM to LAUNCH.
//     LAUNCH (1 cycle): if any slot is free, load the lowest free index with en=1, row=START_ROW,
//       col=player_col+COL_OFFSET (12-bit, wraps), and pulse fire_ack. Otherwise pulse fire_drop.
//       Either way, go to COOLDOWN with the count cleared.
//     COOLDOWN: count motion ticks. On reaching COOLDOWN_TICKS, go to IDLE.
//   Fire request: rising edge of fire_btn (previous-cycle register), taken only in IDLE.
//     Edges seen in LAUNCH or COOLDOWN are discarded.
//   Motion, on motion_tick, for each enabled slot:
//     if row < STEP: en=0, row=0, col=0 (freed);
//     else row -= STEP, col unchanged.
//   Hit: hit_valid with a valid hit_idx frees that slot (en/row/col=0) at the next edge. Hit beats motion on the same slot.
//   Free-slot mask is the registered en. A slot freed in cycle T is allocatable from T+1 only.
//   Launch and tick in the same cycle: the launched slot holds START_ROW (no decrement that cycle).
//   Hit on the slot being launched in the same cycle: ignored (slot was free, launch wins).
//   Latency: fire_btn edge -> fire_ack/en visible = 2 cycles (detect, LAUNCH).
// CONFIGURATION
//   MISSILE_AUTOFIRE_EN defined:
//     fire request = fire_btn level in IDLE.
//     Holding the button relaunches every COOLDOWN_TICKS motion ticks.
//   Not defined:
//     edge-only, one launch per press. Must be released before the next launch.
// STRUCTURE
//   missile_pkg:
//     ms_state_e {IDLE, LAUNCH, COOLDOWN}
//     MAX_MISSILES=16, default START_ROW/STEP/COL_OFFSET localparams
//     function lowest_free(mask) -> index + found flag.
//   Sub-module motion_tick_gen (TICK_DIV): tick counter + motion_tick pulse.
//     Instantiated once; the rest is one FSM plus slot register array.
// TESTING (bench uses TICK_DIV=4, COOLDOWN_TICKS=2, N=8)
//   Reset released, no input:
//     all en=0, fire_ack=0.
//     motion_tick every 4th clk.
//   player_col=312, fire_btn 0->1:
//     fire_ack 2 cycles later, en=8'h01, row0=460, col0=320.
//     Row0 reaches 458 at the next motion_tick.
//   Fire 8 times, each after cooldown: en=8'hFF. 9th press -> fire_drop pulse, en unchanged.
//   Hit:
//     slots 0..2 in flight, hit_valid with hit_idx=1 -> en=8'h05.
//     The next launch takes slot 1.
//   Top of screen: slot row=1 at motion_tick -> en bit 0, row=0, col=0; no fire_ack/drop.
//   Hold fire_btn high 40 clks:
//     without MISSILE_AUTOFIRE_EN, exactly 1 launch;
//     with it, a launch every 2 ticks + LAUNCH cycle.
//   Assert rst mid-flight -> outputs 0 asynchronously.

Source files
------------

// File: rtl/missile_pkg.sv
// Shared types, defaults and the free-slot picker for the missile scheduler.
package missile_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        COOLDOWN = 2'd2
    } ms_state_e;

    localparam int MAX_MISSILES   = 16;
    localparam int DEF_START_ROW  = 460;
    localparam int DEF_STEP       = 2;
    localparam int DEF_COL_OFFSET = 8;
    localparam int POS_W          = 12;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } free_slot_t;

    // Lowest set bit of the free mask; found=0 when no slot is free.
    function automatic free_slot_t lowest_free(input logic [MAX_MISSILES-1:0] mask);
        free_slot_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAX_MISSILES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/missile_scheduler_motion_tick_gen.sv
// Motion tick divider: counts 0..TICK_DIV-1 and pulses o_tick on the last count.
module motion_tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == LAST);
    assign o_tick = w_last;

    // Free-running divider, wraps to 0 in the tick cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + ONE;
        end
    end

endmodule

// File: rtl/missile_scheduler.sv
// Player missile slot pool: fire handling, slot allocation, motion and hit release.
// Build option: define MISSILE_AUTOFIRE_EN to treat a held fire button as a
// repeating request (one launch per cooldown); otherwise one launch per press.
//
// state    | meaning
// IDLE     | waiting for a fire request
// LAUNCH   | one cycle: allocate lowest free slot or report a drop
// COOLDOWN | counting motion ticks before the next request is accepted
module missile_scheduler
    import missile_pkg::*;
#(
    parameter int NUM_MISSILES   = 8,
    parameter int TICK_DIV       = 500000,
    parameter int COOLDOWN_TICKS = 4,
    parameter int START_ROW      = DEF_START_ROW,
    parameter int STEP           = DEF_STEP,
    parameter int COL_OFFSET     = DEF_COL_OFFSET
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_fire_btn,
    input  logic [POS_W-1:0]                i_player_col,
    input  logic                            i_hit_valid,
    input  logic [3:0]                      i_hit_idx,
    output logic [NUM_MISSILES-1:0]         o_missile_en,
    output logic [NUM_MISSILES*POS_W-1:0]   o_missile_row,
    output logic [NUM_MISSILES*POS_W-1:0]   o_missile_col,
    output logic                            o_fire_ack,
    output logic                            o_fire_drop,
    output logic                            o_motion_tick
);

    localparam logic [POS_W-1:0] START_ROW_V  = POS_W'(START_ROW);
    localparam logic [POS_W-1:0] STEP_V       = POS_W'(STEP);
    localparam logic [POS_W-1:0] COL_OFFSET_V = POS_W'(COL_OFFSET);
    localparam logic [15:0]      CD_INIT      = 16'(COOLDOWN_TICKS);

    logic                     w_tick;
    logic                     r_fire_prev;
    logic                     w_fire_req;

    ms_state_e                r_state;
    ms_state_e                w_state_nxt;
    logic [15:0]              r_cd_cnt;
    logic                     w_cd_load;
    logic                     w_cd_dec;

    logic [MAX_MISSILES-1:0]  w_free_mask;
    free_slot_t               w_slot;
    logic                     w_launch;
    logic                     w_ack_nxt;
    logic                     w_drop_nxt;
    logic [POS_W-1:0]         w_launch_col;

    logic                     r_fire_ack;
    logic                     r_fire_drop;
    logic [NUM_MISSILES-1:0]  r_en;
    logic [POS_W-1:0]         r_row [NUM_MISSILES];
    logic [POS_W-1:0]         r_col [NUM_MISSILES];

    motion_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    // Previous-cycle button level for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fire_prev <= 1'b0;
        end else begin
            r_fire_prev <= i_fire_btn;
        end
    end

`ifdef MISSILE_AUTOFIRE_EN
    assign w_fire_req = i_fire_btn;
`else
    assign w_fire_req = i_fire_btn & ~r_fire_prev;
`endif

    // Free slots come from the registered enables only, so a slot released
    // this cycle is not handed out until the next one.
    always_comb begin
        w_free_mask                   = '0;
        w_free_mask[NUM_MISSILES-1:0] = ~r_en;
    end

    assign w_slot       = lowest_free(w_free_mask);
    assign w_launch_col = i_player_col + COL_OFFSET_V;

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and launch decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_ack_nxt   = 1'b0;
        w_drop_nxt  = 1'b0;
        w_cd_load   = 1'b0;
        w_cd_dec    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fire_req) begin
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_launch    = w_slot.found;
                w_ack_nxt   = w_slot.found;
                w_drop_nxt  = ~w_slot.found;
                w_cd_load   = 1'b1;
                w_state_nxt = COOLDOWN;
            end
            COOLDOWN: begin
                if ((r_cd_cnt == 16'd0) || (w_tick && (r_cd_cnt == 16'd1))) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    w_cd_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Cooldown down-counter, loaded on launch and stepped by motion ticks.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cd_cnt <= '0;
        end else if (w_cd_load) begin
            r_cd_cnt <= CD_INIT;
        end else if (w_cd_dec) begin
            r_cd_cnt <= r_cd_cnt - 16'd1;
        end
    end

    // Registered launch result pulses, aligned with the new slot enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fire_ack  <= 1'b0;
            r_fire_drop <= 1'b0;
        end else begin
            r_fire_ack  <= w_ack_nxt;
            r_fire_drop <= w_drop_nxt;
        end
    end

    // Slot array: launch beats hit, hit beats motion.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en <= '0;
            for (int i = 0; i < NUM_MISSILES; i++) begin
                r_row[i] <= '0;
                r_col[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                if (w_launch && (w_slot.idx == 4'(i))) begin
                    r_en[i]  <= 1'b1;
                    r_row[i] <= START_ROW_V;
                    r_col[i] <= w_launch_col;
                end else if (i_hit_valid && (i_hit_idx == 4'(i))) begin
                    r_en[i]  <= 1'b0;
                    r_row[i] <= '0;
                    r_col[i] <= '0;
                end else if (w_tick && r_en[i]) begin
                    if (r_row[i] < STEP_V) begin
                        r_en[i]  <= 1'b0;
                        r_row[i] <= '0;
                        r_col[i] <= '0;
                    end else begin
                        r_row[i] <= r_row[i] - STEP_V;
                    end
                end
            end
        end
    end

    // Pack per-slot positions for the renderer.
    always_comb begin
        o_missile_row = '0;
        o_missile_col = '0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            o_missile_row[POS_W*i +: POS_W] = r_row[i];
            o_missile_col[POS_W*i +: POS_W] = r_col[i];
        end
    end

    assign o_missile_en  = r_en;
    assign o_fire_ack    = r_fire_ack;
    assign o_fire_drop   = r_fire_drop;
    assign o_motion_tick = w_tick;

endmodule

// File: tb/tb_missile_scheduler.sv
// Bench for missile_scheduler: behavioural slot-pool model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_missile_scheduler;

    localparam int N  = 8;
    localparam int TD = 4;
    localparam int CD = 2;
    localparam int SR = 460;
    localparam int ST = 2;
    localparam int CO = 8;
`ifdef MISSILE_AUTOFIRE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            fire = 1'b0;
    logic [11:0]     pcol = 12'd0;
    logic            hit_v = 1'b0;
    logic [3:0]      hidx = 4'd0;
    logic [N-1:0]    en;
    logic [N*12-1:0] row;
    logic [N*12-1:0] col;
    logic            ack;
    logic            drop;
    logic            tick;

    int checks   = 0;
    int failures = 0;

    missile_scheduler #(
        .NUM_MISSILES   (N),
        .TICK_DIV       (TD),
        .COOLDOWN_TICKS (CD)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_fire_btn    (fire),
        .i_player_col  (pcol),
        .i_hit_valid   (hit_v),
        .i_hit_idx     (hidx),
        .o_missile_en  (en),
        .o_missile_row (row),
        .o_missile_col (col),
        .o_fire_ack    (ack),
        .o_fire_drop   (drop),
        .o_motion_tick (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 ready for a request, 1 launch pending, 2 cooling down
    bit m_en [N];
    int m_row [N];
    int m_col [N];
    bit m_ack, m_drop, m_prev;
    int m_cyc, m_mode, m_left, m_ack_count;
    bit n_en [N];
    int n_row [N];
    int n_col [N];
    bit t_now, req;
    int pick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_en[i] = 0; m_row[i] = 0; m_col[i] = 0;
            end
            m_ack = 0; m_drop = 0; m_prev = 0;
            m_cyc = 0; m_mode = 0; m_left = 0;
        end else begin
            t_now = (m_cyc % TD) == (TD - 1);
            req   = AUTO ? fire : (fire && !m_prev);
            n_en  = m_en; n_row = m_row; n_col = m_col;
            pick  = -1;
            m_ack = 0; m_drop = 0;
            if (m_mode == 1) begin
                for (int i = N - 1; i >= 0; i--) if (!m_en[i]) pick = i;
                if (pick >= 0) begin
                    n_en[pick] = 1; n_row[pick] = SR; n_col[pick] = (int'(pcol) + CO) % 4096;
                    m_ack = 1; m_ack_count++;
                end else begin
                    m_drop = 1;
                end
                m_mode = 2; m_left = CD;
            end else if (m_mode == 0) begin
                if (req) m_mode = 1;
            end else begin
                if (t_now) m_left--;
                if (m_left <= 0) m_mode = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (i != pick) begin
                    if (hit_v && int'(hidx) == i) begin
                        n_en[i] = 0; n_row[i] = 0; n_col[i] = 0;
                    end else if (t_now && m_en[i]) begin
                        if (m_row[i] < ST) begin
                            n_en[i] = 0; n_row[i] = 0; n_col[i] = 0;
                        end else begin
                            n_row[i] = m_row[i] - ST;
                        end
                    end
                end
            end
            m_en = n_en; m_row = n_row; m_col = n_col;
            m_cyc++;
            m_prev = fire;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [N-1:0]    e_en;
    logic [N*12-1:0] e_row, e_col;
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                e_en[i]         = m_en[i];
                e_row[12*i +: 12] = 12'(m_row[i]);
                e_col[12*i +: 12] = 12'(m_col[i]);
            end
            chk("model_en", 128'(en), 128'(e_en));
            chk("model_row", 128'(row), 128'(e_row));
            chk("model_col", 128'(col), 128'(e_col));
            chk("model_ack", 128'(ack), 128'(m_ack));
            chk("model_drop", 128'(drop), 128'(m_drop));
            chk("model_tick", 128'(tick), 128'((m_cyc % TD) == (TD - 1)));
        end
    end

    // ---------------- directed helpers ----------------
    // One-cycle press; returns at the negedge after the launch edge.
    task automatic press();
        @(posedge clk); #2; fire = 1'b1;
        @(posedge clk); #2; fire = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sync_reset();
        @(posedge clk); #2; rst = 1'b1; fire = 1'b0; hit_v = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst = 1'b0;
    endtask

    int ticks_seen, first_t, last_t, k, acks0, acks;

    initial begin
        m_ack_count = 0;
        repeat (3) @(posedge clk);
        #2; rst = 1'b0;

        // reset state and tick cadence
        @(negedge clk);
        chk("reset_en", 128'(en), 128'(0));
        chk("reset_ack", 128'(ack), 128'(0));
        ticks_seen = 0; first_t = -1; last_t = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (tick) begin
                ticks_seen++;
                if (first_t < 0) first_t = c;
                last_t = c;
            end
        end
        chk("tick_count", 128'(ticks_seen), 128'(3));
        chk("tick_spacing", 128'(last_t - first_t), 128'(8));

        // first launch at player_col 312
        pcol = 12'd312;
        press();
        chk("first_ack", 128'(ack), 128'(1));
        chk("first_en", 128'(en), 128'(8'h01));
        chk("first_row", 128'(row[11:0]), 128'(460));
        chk("first_col", 128'(col[11:0]), 128'(320));
        k = 0;
        while (!tick && k < 8) begin @(negedge clk); k++; end
        chk("tick_wait", 128'(tick), 128'(1));
        @(negedge clk);
        chk("row_after_tick", 128'(row[11:0]), 128'(458));

        // fill all slots, then one more press is dropped
        for (int p = 0; p < 7; p++) begin
            idle_cycles(12);
            pcol = 12'($urandom_range(0, 4095));
            press();
            chk("fill_ack", 128'(ack), 128'(1));
        end
        chk("full_en", 128'(en), 128'(8'hFF));
        idle_cycles(12);
        press();
        chk("drop_pulse", 128'(drop), 128'(1));
        chk("drop_no_ack", 128'(ack), 128'(0));
        chk("drop_en", 128'(en), 128'(8'hFF));

        // asynchronous reset mid-flight
        @(posedge clk); #3; rst = 1'b1;
        #1;
        chk("arst_en", 128'(en), 128'(0));
        chk("arst_row", 128'(row), 128'(0));
        chk("arst_col", 128'(col), 128'(0));
        chk("arst_ack", 128'(ack | drop), 128'(0));
        chk("arst_tick", 128'(tick), 128'(0));
        @(posedge clk); #2; rst = 1'b0;

        // hit frees slot 1, next launch reuses it
        for (int p = 0; p < 3; p++) begin
            idle_cycles(12);
            press();
        end
        chk("three_en", 128'(en), 128'(8'h07));
        @(posedge clk); #2; hit_v = 1'b1; hidx = 4'd1;
        @(posedge clk); #2; hit_v = 1'b0;
        @(negedge clk);
        chk("hit_en", 128'(en), 128'(8'h05));
        idle_cycles(12);
        pcol = 12'd4090;
        press();
        chk("reuse_en", 128'(en), 128'(8'h07));
        chk("reuse_row", 128'(row[23:12]), 128'(460));
        chk("reuse_col_wrap", 128'(col[23:12]), 128'(2));

        // let every missile fly off the top of the screen
        k = 0;
        while (en != '0 && k < 1200) begin @(negedge clk); k++; end
        chk("top_all_free", 128'(en), 128'(0));
        chk("top_rows_zero", 128'(row), 128'(0));

        // hold the button for 40 clocks
        sync_reset();
        acks0 = m_ack_count;
        acks = 0;
        @(posedge clk); #2; fire = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        @(posedge clk); #2; fire = 1'b0;
        repeat (3) begin @(negedge clk); if (ack) acks++; end
        chk("hold_vs_model", 128'(acks), 128'(m_ack_count - acks0));
        if (AUTO) chk("hold_auto_many", 128'(acks >= 3), 128'(1));
        else      chk("hold_single", 128'(acks), 128'(1));

        // random traffic
        sync_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 7) == 0) fire = ~fire;
            hit_v = ($urandom_range(0, 15) == 0);
            hidx  = 4'($urandom_range(0, 15));
            pcol  = 12'($urandom_range(0, 4095));
        end
        @(posedge clk); #2; fire = 1'b0; hit_v = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
